upsample_2x: RTL and testbench

- 2x2 nearest-neighbour upsampler on a 16-bit ready/valid pixel stream; the inverse of the downsample stage in the image pipeline.
- Each input pixel is emitted twice horizontally, and each input line is emitted twice vertically.
- A one-line buffer of OUT_COLS/2 entries holds the line for its vertical repeat.
- Sits between a low-resolution producer and full-resolution consumers.

---
 rtl/upsample_2x.sv | 62 ++++++
 tb/tb_upsample_2x.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsample_2x.sv
// upsample_2x: 2x2 nearest-neighbour upsampler on a ready/valid pixel stream.
// Define UPSAMPLE_2X_LAST_EN to add data_out_last marking the final pixel of each frame.
module upsample_2x #(
    parameter int DATA_W   = 16,
    parameter int OUT_COLS = 32,
    parameter int OUT_ROWS = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              data_in_valid,
    input  logic [DATA_W-1:0] data_in_data,
    output logic              data_in_ready,
    output logic              data_out_valid,
    output logic [DATA_W-1:0] data_out_data,
`ifdef UPSAMPLE_2X_LAST_EN
    output logic              data_out_last,
`endif
    input  logic              data_out_ready
);
    localparam int XW = $clog2(OUT_COLS);
    localparam int YW = $clog2(OUT_ROWS);
    localparam logic [XW-1:0] X_LAST = XW'(OUT_COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(OUT_ROWS - 1);

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] linebuf [OUT_COLS/2];
    logic              pass;
    logic              adv;

    // Pass-through slot: even column of a fill row forwards the input straight out.
    assign pass = ~y[0] & ~x[0];
    // adv excludes RESET so that RESET only ever reaches flops through their async pin.
    assign adv  = pass ? (data_in_valid & data_out_ready) : data_out_ready;

    always_comb begin
        data_out_valid = RESET ? 1'b0 : (pass ? data_in_valid : 1'b1);
        data_in_ready  = ~RESET & pass & data_in_valid & data_out_ready;
        data_out_data  = pass ? data_in_data : (y[0] ? linebuf[x[XW-1:1]] : hold);
    end

`ifdef UPSAMPLE_2X_LAST_EN
    assign data_out_last = data_out_valid & (x == X_LAST) & (y == Y_LAST);
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            x    <= '0;
            y    <= '0;
            hold <= '0;
        end else if (adv) begin
            x    <= x + 1'b1;
            y    <= (x == X_LAST) ? ((y == Y_LAST) ? '0 : y + 1'b1) : y;
            hold <= pass ? data_in_data : hold;
        end
    end

    always_ff @(posedge CLK)
        if (adv && pass)
            linebuf[x[XW-1:1]] <= data_in_data;
endmodule

// File: tb/tb_upsample_2x.sv
// tb_upsample_2x: randomized self-checking bench for upsample_2x against a frame-beat reference model.
module tb_upsample_2x;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_v = 1'b0;
    logic [15:0] in_d = '0;
    logic        out_r = 1'b0;
    logic        in_r;
    logic        out_v;
    logic [15:0] out_d;
    logic        last_w;

    int checks = 0;
    int errors = 0;

    int          k = 0;
    logic [15:0] line [16];

    always #5 CLK = ~CLK;

    upsample_2x dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .data_in_valid (in_v),
        .data_in_data  (in_d),
        .data_in_ready (in_r),
        .data_out_valid(out_v),
        .data_out_data (out_d),
`ifdef UPSAMPLE_2X_LAST_EN
        .data_out_last (last_w),
`endif
        .data_out_ready(out_r)
    );
`ifndef UPSAMPLE_2X_LAST_EN
    assign last_w = 1'b0;
`endif

    // Model: k is the output beat index within a 32x32 frame.
    function automatic logic m_pass();
        return ((k / 32) % 2 == 0) && ((k % 32) % 2 == 0);
    endfunction
    function automatic logic m_valid(input logic v);
        return m_pass() ? v : 1'b1;
    endfunction
    function automatic logic [15:0] m_data(input logic [15:0] d);
        return m_pass() ? d : line[(k % 32) / 2];
    endfunction
    function automatic logic m_in_ready(input logic v, input logic r);
        return m_pass() & v & r;
    endfunction
    function automatic logic m_last(input logic v);
        return m_valid(v) && (k == 1023);
    endfunction
    task automatic m_step(input logic v, input logic [15:0] d, input logic r);
        if (m_valid(v) && r) begin
            if (m_pass()) line[(k % 32) / 2] = d;
            k = (k + 1) % 1024;
        end
    endtask

    task automatic beat(input logic v, input logic [15:0] d, input logic r,
                        output logic ov, output logic [15:0] od, output logic ir, output logic ol);
        in_v = v; in_d = d; out_r = r;
        @(negedge CLK);
        ov = out_v; od = out_d; ir = in_r; ol = last_w;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        in_v = 1'b1; out_r = 1'b1;
        #2;
        checks++;
        if (out_v !== 1'b0 || in_r !== 1'b0 || last_w !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs got v=%b ir=%b last=%b want 0 0 0", out_v, in_r, last_w);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        k = 0;
    endtask

    task automatic test_fill_repeat();
        logic ov, ir, ol;
        logic [15:0] od, d, base;
        for (int p = 0; p < 2; p++) begin
            base = (p == 0) ? 16'd0 : 16'd100;
            for (int i = 0; i < 64; i++) begin
                d = (i < 32) ? base + 16'(i / 2) : 16'($urandom);
                beat(1'b1, d, 1'b1, ov, od, ir, ol);
                checks++;
                if (ov !== m_valid(1'b1) || od !== m_data(d) || ir !== m_in_ready(1'b1, 1'b1)) begin
                    errors++;
                    $display("FAIL fill_repeat k=%0d got v=%b d=%0d ir=%b want v=%b d=%0d ir=%b",
                             k, ov, od, ir, m_valid(1'b1), m_data(d), m_in_ready(1'b1, 1'b1));
                end
                checks++;
                if (od !== base + 16'((i % 32) / 2)) begin
                    errors++;
                    $display("FAIL row_value i=%0d got %0d want %0d", i, od, base + 16'((i % 32) / 2));
                end
                m_step(1'b1, d, 1'b1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic ov, ir, ol, r;
        logic [15:0] od, d;
        int n = 0;
        for (int t = 0; t < 67; t++) begin
            r = !(t >= 5 && t < 8);
            d = 16'(n);
            beat(1'b1, d, r, ov, od, ir, ol);
            checks++;
            if (ov !== m_valid(1'b1) || (ov && od !== m_data(d)) || ir !== m_in_ready(1'b1, r)) begin
                errors++;
                $display("FAIL backpressure t=%0d got v=%b d=%0d ir=%b want v=%b d=%0d ir=%b",
                         t, ov, od, ir, m_valid(1'b1), m_data(d), m_in_ready(1'b1, r));
            end
            if ((t >= 5 && t <= 8) || t == 9) begin
                checks++;
                if (od !== ((t == 9) ? 16'd3 : 16'd2) || (t < 9 && ir !== 1'b0)) begin
                    errors++;
                    $display("FAIL stall_hold t=%0d got d=%0d ir=%b want d=%0d ir=0",
                             t, od, ir, (t == 9) ? 3 : 2);
                end
            end
            if (ir) n++;
            m_step(1'b1, d, r);
        end
    endtask

    task automatic test_starvation();
        logic ov, ir, ol, v;
        logic [15:0] od, d;
        int n = 0;
        for (int t = 0; t < 68; t++) begin
            v = !(t >= 8 && t < 12);
            d = 16'(n);
            beat(v, d, 1'b1, ov, od, ir, ol);
            checks++;
            if (ov !== m_valid(v) || (ov && od !== m_data(d)) || ir !== m_in_ready(v, 1'b1)) begin
                errors++;
                $display("FAIL starvation t=%0d got v=%b d=%0d ir=%b want v=%b d=%0d ir=%b",
                         t, ov, od, ir, m_valid(v), m_data(d), m_in_ready(v, 1'b1));
            end
            if (t >= 8 && t <= 12) begin
                checks++;
                if ((t < 12 && ov !== 1'b0) || (t == 12 && (od !== 16'd4 || ir !== 1'b1 || ov !== 1'b1))) begin
                    errors++;
                    $display("FAIL starve_slot t=%0d got v=%b d=%0d ir=%b want %s",
                             t, ov, od, ir, (t < 12) ? "v=0" : "v=1 d=4 ir=1");
                end
            end
            if (ir) n++;
            m_step(v, d, 1'b1);
        end
    endtask

    task automatic test_random();
        logic ov, ir, ol, v, r;
        logic [15:0] od, d;
        for (int t = 0; t < 500; t++) begin
            v = 1'($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 3) != 0);
            d = 16'($urandom);
            beat(v, d, r, ov, od, ir, ol);
            checks++;
            if (ov !== m_valid(v) || (ov && od !== m_data(d)) || ir !== m_in_ready(v, r)) begin
                errors++;
                $display("FAIL random k=%0d got v=%b d=%0d ir=%b want v=%b d=%0d ir=%b",
                         k, ov, od, ir, m_valid(v), m_data(d), m_in_ready(v, r));
            end
            m_step(v, d, r);
        end
    endtask

    task automatic test_reset_mid();
        logic ov, ir, ol;
        logic [15:0] od, d;
        int t = 0;
        while (k % 64 != 52 && t < 200) begin
            d = 16'($urandom);
            beat(1'b1, d, 1'b1, ov, od, ir, ol);
            m_step(1'b1, d, 1'b1);
            t++;
        end
        checks++;
        if (k % 64 != 52) begin
            errors++;
            $display("FAIL reach_x20 got k=%0d want k%%64=52", k);
        end
        in_v = 1'b1; out_r = 1'b1;
        #2 RESET = 1'b1;
        #1;
        checks++;
        if (out_v !== 1'b0 || in_r !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b ir=%b want 0 0", out_v, in_r);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        k = 0;
        beat(1'b1, 16'd7, 1'b1, ov, od, ir, ol);
        checks++;
        if (ov !== 1'b1 || od !== 16'd7 || ir !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_first got v=%b d=%0d ir=%b want 1 7 1", ov, od, ir);
        end
        m_step(1'b1, 16'd7, 1'b1);
        beat(1'b1, 16'd8, 1'b1, ov, od, ir, ol);
        checks++;
        if (ov !== 1'b1 || od !== 16'd7 || ir !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_second got v=%b d=%0d ir=%b want 1 7 0", ov, od, ir);
        end
        m_step(1'b1, 16'd8, 1'b1);
    endtask

    task automatic test_frame();
        logic ov, ir, ol, r;
        logic [15:0] od, d;
        int beats = 0, stall = 0, lasts = 0, t = 0;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        k = 0;
        while (beats < 1024 + 70 && t < 1300) begin
            r = !(k == 1023 && stall < 2);
            if (k == 1023 && !r) stall++;
            d = 16'($urandom);
            beat(1'b1, d, r, ov, od, ir, ol);
            checks++;
            if (ov !== m_valid(1'b1) || (ov && od !== m_data(d)) || ir !== m_in_ready(1'b1, r)) begin
                errors++;
                $display("FAIL frame k=%0d got v=%b d=%0d ir=%b want v=%b d=%0d ir=%b",
                         k, ov, od, ir, m_valid(1'b1), m_data(d), m_in_ready(1'b1, r));
            end
`ifdef UPSAMPLE_2X_LAST_EN
            checks++;
            if (ol !== m_last(1'b1)) begin
                errors++;
                $display("FAIL last k=%0d got %b want %b", k, ol, m_last(1'b1));
            end
`endif
            if (ol) lasts++;
            if (ov && r) beats++;
            m_step(1'b1, d, r);
            t++;
        end
        checks++;
        if (beats != 1024 + 70) begin
            errors++;
            $display("FAIL frame_budget got %0d beats want %0d", beats, 1024 + 70);
        end
`ifdef UPSAMPLE_2X_LAST_EN
        checks++;
        if (lasts != 3) begin
            errors++;
            $display("FAIL last_count got %0d want 3", lasts);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fill_repeat();
        test_backpressure();
        test_starvation();
        test_random();
        test_reset_mid();
        test_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end
endmodule
